// File: rtl/issue_perf_monitor.sv
// Issue-stage performance monitor: event counters for issue, thread activity and stalls,
// with sticky overflow flags and a one-cycle-latency indexed readback port.
module issue_perf_monitor #(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned NUM_UNITS   = 5,
  parameter int unsigned CTR_W       = 44,
  parameter bit          SATURATE    = 1'b1,
  localparam int unsigned NUM_CTRS   = 3 + NUM_UNITS,
  localparam int unsigned AW         = $clog2(NUM_CTRS),
  localparam int unsigned PW         = $clog2(NUM_THREADS + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   issue_valid,
  input  logic                   issue_ready,
  input  logic [NUM_THREADS-1:0] issue_tmask,
  input  logic                   scb_delay,
  input  logic [NUM_UNITS-1:0]   unit_valid,
  input  logic [NUM_UNITS-1:0]   unit_ready,
  input  logic                   perf_en,
  input  logic                   perf_clr,
  input  logic                   rd_req,
  input  logic [AW-1:0]          rd_addr,
  output logic                   rd_valid,
  output logic [CTR_W-1:0]       rd_data,
  output logic [PW-1:0]          last_active,
  output logic [NUM_CTRS-1:0]    ovf_flags
);

  logic                fire;
  logic [PW-1:0]       popcnt;
  logic [PW-1:0]       inc      [NUM_CTRS];
  logic [CTR_W:0]      sum      [NUM_CTRS];
  logic [CTR_W-1:0]    ctr_q    [NUM_CTRS];
  logic [CTR_W-1:0]    ctr_d    [NUM_CTRS];
  logic [NUM_CTRS-1:0] ovf_q, ovf_d;
  logic [PW-1:0]       last_active_q;
  logic                rd_valid_q;
  logic [CTR_W-1:0]    rd_data_q, rd_data_d;
  logic [CTR_W-1:0]    rd_mux;

  assign fire = issue_valid & issue_ready;

  always_comb begin
    popcnt = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      popcnt = popcnt + PW'(issue_tmask[t]);
    end
  end

  // Per-counter increment; unit stall counters follow the fixed ones in channel order.
  always_comb begin
    inc    = '{default: '0};
    inc[0] = PW'(fire);
    inc[1] = fire ? popcnt : '0;
    inc[2] = PW'(issue_valid & scb_delay);
    for (int k = 0; k < NUM_UNITS; k++) begin
      inc[3+k] = PW'(unit_valid[k] & ~unit_ready[k]);
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < NUM_CTRS; i++) begin
      sum[i]   = {1'b0, ctr_q[i]} + (CTR_W+1)'(inc[i]);
      ctr_d[i] = ctr_q[i];
      if (perf_clr) begin
        ctr_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (perf_en) begin
        if (sum[i][CTR_W]) begin
          ovf_d[i] = 1'b1;
          ctr_d[i] = SATURATE ? {CTR_W{1'b1}} : sum[i][CTR_W-1:0];
        end else begin
          ctr_d[i] = sum[i][CTR_W-1:0];
        end
      end
    end
  end

  // Decoded mux keeps rd_addr from propagating X; out-of-range indices read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CTRS; i++) begin
      if (rd_addr == AW'(i)) begin
        rd_mux = ctr_q[i];
      end
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_req) begin
      rd_data_d = rd_mux;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CTRS; i++) begin
        ctr_q[i] <= '0;
      end
      ovf_q         <= '0;
      last_active_q <= '0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      for (int i = 0; i < NUM_CTRS; i++) begin
        ctr_q[i] <= ctr_d[i];
      end
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_req;
      rd_data_q  <= rd_data_d;
      if (fire) begin
        last_active_q <= popcnt;
      end
    end
  end

  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign last_active = last_active_q;
  assign ovf_flags   = ovf_q;

endmodule

// File: tb/tb_issue_perf_monitor.sv
// Directed bench for issue_perf_monitor: a 44-bit default instance plus 4-bit saturating and
// wrapping instances (four units, so index 7 is out of range) sharing one stimulus stream.
module tb_issue_perf_monitor;

  logic       clk;
  logic       reset_n;
  logic       issue_valid, issue_ready, scb_delay;
  logic [3:0] issue_tmask;
  logic [4:0] unit_valid, unit_ready;
  logic       perf_en, perf_clr, rd_req;
  logic [2:0] rd_addr;

  logic        m_rd_valid, s_rd_valid, w_rd_valid;
  logic [43:0] m_rd_data;
  logic [3:0]  s_rd_data, w_rd_data;
  logic [2:0]  m_last, s_last, w_last;
  logic [7:0]  m_ovf;
  logic [6:0]  s_ovf, w_ovf;

  int total = 0;
  int bad   = 0;

  issue_perf_monitor u_main (
    .clk(clk), .reset_n(reset_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_tmask(issue_tmask), .scb_delay(scb_delay), .unit_valid(unit_valid),
    .unit_ready(unit_ready), .perf_en(perf_en), .perf_clr(perf_clr), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_valid(m_rd_valid), .rd_data(m_rd_data), .last_active(m_last),
    .ovf_flags(m_ovf)
  );

  issue_perf_monitor #(.NUM_UNITS(4), .CTR_W(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset_n(reset_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_tmask(issue_tmask), .scb_delay(scb_delay), .unit_valid(unit_valid[3:0]),
    .unit_ready(unit_ready[3:0]), .perf_en(perf_en), .perf_clr(perf_clr), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_valid(s_rd_valid), .rd_data(s_rd_data), .last_active(s_last),
    .ovf_flags(s_ovf)
  );

  issue_perf_monitor #(.NUM_UNITS(4), .CTR_W(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset_n(reset_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_tmask(issue_tmask), .scb_delay(scb_delay), .unit_valid(unit_valid[3:0]),
    .unit_ready(unit_ready[3:0]), .perf_en(perf_en), .perf_clr(perf_clr), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_valid(w_rd_valid), .rd_data(w_rd_data), .last_active(w_last),
    .ovf_flags(w_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic rd(input int addr);
    rd_req  = 1'b1;
    rd_addr = 3'(addr);
    tick();
    rd_req  = 1'b0;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    issue_ready = 1'b0;
    issue_tmask = 4'b0000;
    scb_delay   = 1'b0;
    unit_valid  = 5'b00000;
    unit_ready  = 5'b00000;
  endtask

  logic [3:0] masks [10] = '{4'b1111, 4'b0101, 4'b0001, 4'b1111, 4'b0101,
                             4'b0001, 4'b1111, 4'b0101, 4'b1111, 4'b0001};
  logic [43:0] simul_exp [8] = '{44'd1, 44'd2, 44'd1, 44'd1, 44'd0, 44'd1, 44'd0, 44'd1};

  initial begin
    reset_n  = 1'b0;
    idle();
    perf_en  = 1'b0;
    perf_clr = 1'b0;
    rd_req   = 1'b0;
    rd_addr  = 3'd0;
    repeat (3) tick();
    chk("reset_rd_valid", 64'(m_rd_valid), 64'd0);
    chk("reset_rd_data", 64'(m_rd_data), 64'd0);
    chk("reset_last_active", 64'(m_last), 64'd0);
    chk("reset_ovf", 64'(m_ovf), 64'd0);
    reset_n = 1'b1;
    tick();

    // Back-to-back readback of every index after reset
    for (int a = 0; a < 8; a++) begin
      rd_req  = 1'b1;
      rd_addr = 3'(a);
      tick();
      chk($sformatf("reset_read_valid_%0d", a), 64'(m_rd_valid), 64'd1);
      chk($sformatf("reset_read_data_%0d", a), 64'(m_rd_data), 64'd0);
    end
    rd_req = 1'b0;
    tick();
    chk("idle_rd_valid", 64'(m_rd_valid), 64'd0);

    // Issue counting: 4x1111, 3x0101, 3x0001 -> 10 issues, 25 active threads
    perf_en     = 1'b1;
    issue_valid = 1'b1;
    issue_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      issue_tmask = masks[i];
      tick();
    end
    idle();
    chk("issue_last_active", 64'(m_last), 64'd1);
    rd(0); chk("issue_count", 64'(m_rd_data), 64'd10);
    rd(1); chk("active_sum", 64'(m_rd_data), 64'd25);
    rd(2); chk("scb_before_stall", 64'(m_rd_data), 64'd0);
    chk("issue_ovf", 64'(m_ovf), 64'd0);

    // Stalls: 7 scb cycles, unit 2 stalled for first 5, enable low in cycles 2 and 3
    issue_valid = 1'b1;
    scb_delay   = 1'b1;
    for (int c = 0; c < 7; c++) begin
      perf_en    = !(c == 2 || c == 3);
      unit_valid = (c < 5) ? 5'b00100 : 5'b00000;
      tick();
    end
    idle();
    perf_en = 1'b1;
    rd(2); chk("scb_stalls", 64'(m_rd_data), 64'd5);
    rd(3); chk("unit0_stalls", 64'(m_rd_data), 64'd0);
    rd(4); chk("unit1_stalls", 64'(m_rd_data), 64'd0);
    rd(0); chk("issue_after_stall", 64'(m_rd_data), 64'd10);
    rd(5); chk("unit2_stalls", 64'(m_rd_data), 64'd3);
    tick();
    chk("hold_rd_valid", 64'(m_rd_valid), 64'd0);
    chk("hold_rd_data", 64'(m_rd_data), 64'd3);

    // last_active follows fires even with counting disabled
    perf_en     = 1'b0;
    issue_valid = 1'b1;
    issue_ready = 1'b1;
    issue_tmask = 4'b0111;
    tick();
    idle();
    perf_en = 1'b1;
    chk("last_active_disabled", 64'(m_last), 64'd3);
    rd(0); chk("issue_disabled_fire", 64'(m_rd_data), 64'd10);

    // Clear beats a same-cycle fire; same-cycle read returns the pre-clear value
    issue_valid = 1'b1;
    issue_ready = 1'b1;
    issue_tmask = 4'b1111;
    perf_clr    = 1'b1;
    rd_req      = 1'b1;
    rd_addr     = 3'd0;
    tick();
    idle();
    perf_clr = 1'b0;
    rd_req   = 1'b0;
    chk("clr_read_valid", 64'(m_rd_valid), 64'd1);
    chk("clr_read_old", 64'(m_rd_data), 64'd10);
    chk("clr_ovf", 64'(s_ovf), 64'd0);
    rd(0); chk("clr_issue", 64'(m_rd_data), 64'd0);
    rd(1); chk("clr_active", 64'(m_rd_data), 64'd0);
    chk("clr_keeps_last_active", 64'(m_last), 64'd4);

    // Simultaneous events across every counter in one cycle
    issue_valid = 1'b1;
    issue_ready = 1'b1;
    issue_tmask = 4'b0011;
    scb_delay   = 1'b1;
    unit_valid  = 5'b11111;
    unit_ready  = 5'b01010;
    tick();
    idle();
    for (int a = 0; a < 8; a++) begin
      rd(a);
      chk($sformatf("simul_ctr_%0d", a), 64'(m_rd_data), 64'(simul_exp[a]));
    end

    // Overflow: 17 fires of 1111 on 4-bit counters
    perf_clr = 1'b1;
    tick();
    perf_clr    = 1'b0;
    issue_valid = 1'b1;
    issue_ready = 1'b1;
    issue_tmask = 4'b1111;
    repeat (17) tick();
    idle();
    rd(0);
    chk("main_issue_17", 64'(m_rd_data), 64'd17);
    chk("sat_issue", 64'(s_rd_data), 64'd15);
    chk("wrap_issue", 64'(w_rd_data), 64'd1);
    rd(1);
    chk("main_active_68", 64'(m_rd_data), 64'd68);
    chk("sat_active", 64'(s_rd_data), 64'd15);
    chk("wrap_active", 64'(w_rd_data), 64'd4);
    chk("sat_ovf", 64'(s_ovf), 64'd3);
    chk("wrap_ovf", 64'(w_ovf), 64'd3);
    chk("main_no_ovf", 64'(m_ovf), 64'd0);
    rd(7);
    chk("oor_valid", 64'(s_rd_valid), 64'd1);
    chk("oor_sat_data", 64'(s_rd_data), 64'd0);
    chk("oor_wrap_data", 64'(w_rd_data), 64'd0);

    // Asynchronous reset between edges during a read burst
    rd_req  = 1'b1;
    rd_addr = 3'd0;
    tick();
    chk("burst_valid", 64'(m_rd_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rd_valid", 64'(m_rd_valid), 64'd0);
    chk("async_rd_data", 64'(m_rd_data), 64'd0);
    chk("async_sat_ovf", 64'(s_ovf), 64'd0);
    chk("async_last_active", 64'(m_last), 64'd0);
    rd_req = 1'b0;
    #1 reset_n = 1'b1;
    tick();
    rd(0);
    chk("post_reset_issue", 64'(m_rd_data), 64'd0);
    chk("post_reset_sat_issue", 64'(s_rd_data), 64'd0);
    rd(1);
    chk("post_reset_active", 64'(m_rd_data), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/issue_perf_monitor.md
Name: issue_perf_monitor

Overview:
- Parametrised issue-stage performance monitor that sits beside the issue stage.
- Observes the issue handshake, the scoreboard stall and the per-execution-unit request handshakes.
- Keeps a bank of 64-bit-capable event counters: issued instructions, cumulative active threads, scoreboard stalls and per-unit stalls. Adds a registered last-issue thread count, sticky overflow flags, saturating or wrapping arithmetic, synchronous clear/enable, and an indexed registered readback port for CSR access.

Parameters:
- NUM_THREADS, 4, width of the issue thread mask.
- NUM_UNITS, 5, number of execution-unit request channels (ALU, LSU, CSR, FPU, GPU order).
- CTR_W, 44, width of every counter.
- SATURATE, 1, 1 = counters stick at all-ones; 0 = counters wrap to 0.
- NUM_CTRS, 3+NUM_UNITS, derived, total counters.
- AW, $clog2(NUM_CTRS), derived, readback address width.
- PW, $clog2(NUM_THREADS+1), derived, popcount width.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  issue-stage instruction valid.
- issue_ready  in  1  issue-stage accept.
- issue_tmask  in  NUM_THREADS  thread mask of the issuing instruction.
- scb_delay  in  1  scoreboard hazard stall.
- unit_valid  in  NUM_UNITS  per-unit request valid.
- unit_ready  in  NUM_UNITS  per-unit request ready.
- perf_en  in  1  count enable.
- perf_clr  in  1  synchronous clear of all counters and flags.
- rd_req  in  1  readback request.
- rd_addr  in  AW  counter index to read.
- rd_valid  out  1  readback data valid.
- rd_data  out  CTR_W  readback value.
- last_active  out  PW  popcount of the most recently issued tmask.
- ovf_flags  out  NUM_CTRS  sticky per-counter overflow flags.

Behaviour:
- Counter map:
  - 0 = issue_count (+1 when issue_valid&issue_ready).
  - 1 = active_sum (+popcount(issue_tmask) on the same fire).
  - 2 = scb_stalls (+1 when issue_valid&scb_delay).
  - 3+k = stalls of unit k (+1 when unit_valid[k]&!unit_ready[k]).
- Reset (reset_n low, asynchronous): all counters 0, ovf_flags 0, last_active 0, rd_valid 0, rd_data 0. Deassertion takes effect on the next clk edge.
- Counters update only when perf_en=1. last_active updates on every issue fire regardless of perf_en.
- perf_clr=1 forces all counters and ovf_flags to 0 on the next edge. Clear has priority over any same-cycle increment, and the event in that cycle is lost. last_active is not cleared.
- Arithmetic: the increment is zero-extended to CTR_W+1 bits.
  - If the sum carries out: ovf_flags[i] is set (sticky until perf_clr/reset).
  - SATURATE=1: the counter becomes all-ones.
  - SATURATE=0: the counter keeps the low CTR_W bits.
  - A saturated counter receiving a further nonzero increment keeps ovf set and keeps its value.
  - A zero increment (fire with tmask=0) never sets ovf.
- Popcount is purely combinational on issue_tmask; issue fire samples it in the same cycle.
- Readback has 1-cycle latency: rd_req in cycle N gives rd_valid=1 and rd_data in cycle N+1.
  - rd_data is the counter value before any cycle-N update, i.e. the registered value at edge N, not including cycle N's event.
  - rd_addr>=NUM_CTRS returns rd_data=0 with rd_valid=1.
  - Without rd_req, rd_valid=0 and rd_data holds its last value.
  - Back-to-back requests are supported every cycle.
  - A read in the same cycle as perf_clr returns the pre-clear value.
- Simultaneous events on different counters all update in the same cycle; there is no arbitration.
- No X propagation from rd_addr when rd_req=0.
- All unit counters are generated by a NUM_UNITS loop; no per-unit special cases.

Test Plan:
- Reset/readback: hold reset_n low 3 cycles, release, then rd_req addr 0..7 -> rd_valid 1 cycle later each, all rd_data=0, ovf_flags=0.
- Issue counting: perf_en=1, 10 fires with tmask 4'b1111, 4'b0101, 4'b0001 alternating (4 of 1111, 3 of 0101, 3 of 0001) -> issue_count=10, active_sum=25, last_active=1.
- Stalls: issue_valid=1, scb_delay=1 for 7 cycles; unit_valid[2]=1, unit_ready[2]=0 for 5 cycles; perf_en dropped for 2 of those cycles -> scb_stalls=5, counter 5 = 3, others 0.
- Clear priority: fire and perf_clr in the same cycle, with rd_req addr 0 -> rd_data = old count; next read=0; ovf cleared.
- Saturation: CTR_W=4, SATURATE=1, 16 fires with tmask 4'b1111 -> active_sum=15, ovf_flags[1]=1, issue_count=15, ovf_flags[0]=1. With SATURATE=0, 17 fires -> issue_count=1, ovf_flags[0]=1.
- Async reset mid-operation: assert reset_n low between edges during a read burst -> rd_valid drops immediately, counters 0, and no increment on the first edge after release if events are idle.
